// File: rtl/activation_unit.sv
// Two-stage activation pipeline: ReLU / leaky / clipped / saturating pass with rescale.
// Define ACT_ROUND_EN to round half-up before saturation instead of truncating.
module activation_unit #(
  parameter int unsigned dataWidth      = 16,
  parameter int unsigned weightIntWidth = 4,
  parameter int unsigned leakShiftWidth = 3,
  parameter int unsigned satCntWidth    = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [2*dataWidth-1:0]    num,
  input  logic [1:0]                mode,
  input  logic [leakShiftWidth-1:0] leak_shift,
  input  logic [dataWidth-1:0]      clip_max,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [dataWidth-1:0]      out,
  output logic                      out_sat,
  output logic [satCntWidth-1:0]    sat_count,
  input  logic                      sat_clear
);

  localparam int unsigned W       = 2 * dataWidth;
  localparam int unsigned SliceHi = W - 1 - weightIntWidth;
  localparam int unsigned SliceLo = SliceHi - dataWidth + 1;
`ifdef ACT_ROUND_EN
  localparam int unsigned LoBit   = SliceLo - 1;
`else
  localparam int unsigned LoBit   = SliceLo;
`endif
  localparam int unsigned StoreW  = W - LoBit;

  localparam logic [dataWidth-1:0] MaxPos = {1'b0, {(dataWidth - 1){1'b1}}};
  localparam logic [dataWidth-1:0] MaxNeg = {1'b1, {(dataWidth - 1){1'b0}}};

  typedef enum logic [1:0] {
    ModeRelu  = 2'd0,
    ModeLeaky = 2'd1,
    ModeClip  = 2'd2,
    ModePass  = 2'd3
  } mode_e;

  // Stage 1 state; only the bits of p that stage 2 reads are kept
  logic                   s1_valid_q;
  logic                   s1_clip_q, s1_clip_d;
  logic [dataWidth-1:0]   s1_clip_max_q;
  logic [W-1:LoBit]       s1_p_q, s1_p_d;

  // Stage 2 / output state
  logic                   out_valid_q;
  logic [dataWidth-1:0]   out_q, out_d;
  logic                   out_sat_q, out_sat_d;
  logic [satCntWidth-1:0] sat_count_q, sat_count_d;

  logic s1_advance;
  logic signed [W-1:0] num_s, shifted, p_full;

  assign s1_advance = !out_valid_q | out_ready;
  assign in_ready   = !s1_valid_q | s1_advance;

  always_comb begin
    num_s     = $signed(num);
    shifted   = num_s >>> leak_shift;
    p_full    = num_s;
    s1_clip_d = 1'b0;
    case (mode_e'(mode))
      ModeRelu: begin
        if (num_s[W-1]) p_full = '0;
      end
      ModeClip: begin
        s1_clip_d = 1'b1;
        if (num_s[W-1]) p_full = '0;
      end
      ModeLeaky: begin
        if (num_s[W-1]) p_full = shifted;
      end
      default: ;
    endcase
    s1_p_d = StoreW'(p_full >> LoBit);
  end

  logic [weightIntWidth:0] top_bits;
  logic [dataWidth-1:0]    slice;
  logic [dataWidth-1:0]    scaled;
  logic                    ovf_pos, ovf_neg, rnd_ovf;
`ifdef ACT_ROUND_EN
  logic [dataWidth:0]      rnd;
`endif

  always_comb begin
    top_bits = s1_p_q[W-1 -: weightIntWidth + 1];
    slice    = s1_p_q[SliceHi -: dataWidth];
    ovf_pos  = !s1_p_q[W-1] && (top_bits != '0);
    ovf_neg  = s1_p_q[W-1] && (top_bits != '1);
`ifdef ACT_ROUND_EN
    // Extra MSB catches the carry out of the largest positive slice
    rnd      = {slice[dataWidth-1], slice} + {{dataWidth{1'b0}}, s1_p_q[LoBit]};
    rnd_ovf  = rnd[dataWidth] != rnd[dataWidth-1];
    scaled   = rnd[dataWidth-1:0];
`else
    rnd_ovf  = 1'b0;
    scaled   = slice;
`endif
    out_sat_d = 1'b0;
    if (ovf_pos || rnd_ovf) begin
      out_d     = MaxPos;
      out_sat_d = 1'b1;
    end else if (ovf_neg) begin
      out_d     = MaxNeg;
      out_sat_d = 1'b1;
    end else begin
      out_d     = scaled;
    end
    if (s1_clip_q && (out_d > s1_clip_max_q)) begin
      out_d     = s1_clip_max_q;
      out_sat_d = 1'b1;
    end
  end

  always_comb begin
    sat_count_d = sat_count_q;
    if (sat_clear) begin
      sat_count_d = '0;
    end else if (out_valid_q && out_ready && out_sat_q && (sat_count_q != '1)) begin
      sat_count_d = sat_count_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_q       <= '0;
      out_sat_q   <= 1'b0;
      sat_count_q <= '0;
    end else begin
      if (in_ready) begin
        s1_valid_q <= in_valid;
        if (in_valid) begin
          s1_p_q        <= s1_p_d;
          s1_clip_q     <= s1_clip_d;
          s1_clip_max_q <= clip_max;
        end
      end
      if (s1_advance) begin
        out_valid_q <= s1_valid_q;
        if (s1_valid_q) begin
          out_q     <= out_d;
          out_sat_q <= out_sat_d;
        end
      end
      sat_count_q <= sat_count_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out       = out_q;
  assign out_sat   = out_sat_q;
  assign sat_count = sat_count_q;

endmodule

// File: tb/tb_activation_unit.sv
// Directed bench for activation_unit: modes, saturation, clip, backpressure, counter, reset.
module tb_activation_unit;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] num;
  logic [1:0]  mode;
  logic [2:0]  leak_shift;
  logic [15:0] clip_max;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out;
  logic        out_sat;
  logic [15:0] sat_count;
  logic        sat_clear;

  int checks   = 0;
  int failures = 0;

`ifdef ACT_ROUND_EN
  localparam logic [15:0] RoundExp = 16'h0001;
`else
  localparam logic [15:0] RoundExp = 16'h0000;
`endif

  activation_unit dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .num        (num),
    .mode       (mode),
    .leak_shift (leak_shift),
    .clip_max   (clip_max),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out        (out),
    .out_sat    (out_sat),
    .sat_count  (sat_count),
    .sat_clear  (sat_clear)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp_v);
    end
  endtask

  // One beat through an empty pipeline with out_ready high; entered/left at posedge+1
  task automatic beat(input string tag, input logic [31:0] n, input logic [1:0] m,
                      input logic [2:0] ls, input logic [15:0] cm,
                      input logic [15:0] exp_out, input logic exp_sat, input logic clr);
    num        = n;
    mode       = m;
    leak_shift = ls;
    clip_max   = cm;
    in_valid   = 1'b1;
    #1;
    chk({tag, "_in_ready"}, 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk({tag, "_lat1_valid"}, 32'(out_valid), 32'd0);
    @(posedge clk); #1;
    chk({tag, "_valid"}, 32'(out_valid), 32'd1);
    chk({tag, "_out"}, 32'(out), 32'(exp_out));
    chk({tag, "_sat"}, 32'(out_sat), 32'(exp_sat));
    sat_clear = clr;
    @(posedge clk); #1;
    sat_clear = 1'b0;
  endtask

  logic [31:0] bp_num [5];
  logic [15:0] bp_exp [5];
  logic [15:0] held;
  logic        take_in;
  int          sent;
  int          got;

  initial begin
    rst_n      = 1'b0;
    in_valid   = 1'b0;
    num        = '0;
    mode       = 2'd0;
    leak_shift = '0;
    clip_max   = '0;
    out_ready  = 1'b1;
    sat_clear  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out", 32'(out), 32'd0);
    chk("rst_out_sat", 32'(out_sat), 32'd0);
    chk("rst_sat_count", 32'(sat_count), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_in_ready", 32'(in_ready), 32'd1);

    beat("relu_pos", 32'h0100_0000, 2'd0, 3'd0, 16'h0, 16'h1000, 1'b0, 1'b0);
    beat("relu_neg", 32'hFFFF_F000, 2'd0, 3'd0, 16'h0, 16'h0000, 1'b0, 1'b0);
    chk("cnt0", 32'(sat_count), 32'd0);
    beat("relu_ovf", 32'h0800_0000, 2'd0, 3'd0, 16'h0, 16'h7FFF, 1'b1, 1'b0);
    chk("cnt1", 32'(sat_count), 32'd1);
    beat("pass_neg_ovf", 32'hF000_0000, 2'd3, 3'd0, 16'h0, 16'h8000, 1'b1, 1'b0);
    chk("cnt2", 32'(sat_count), 32'd2);
    beat("leaky_sh3", 32'hFFF8_0000, 2'd1, 3'd3, 16'h0, 16'hFFF0, 1'b0, 1'b0);
    beat("leaky_sh0", 32'hFFF8_0000, 2'd1, 3'd0, 16'h0, 16'hFF80, 1'b0, 1'b0);
    beat("clip_hit", 32'h0100_0000, 2'd2, 3'd0, 16'h0800, 16'h0800, 1'b1, 1'b0);
    beat("clip_miss", 32'h0040_0000, 2'd2, 3'd0, 16'h0800, 16'h0400, 1'b0, 1'b0);
    chk("cnt3", 32'(sat_count), 32'd3);

    // Backpressure: out_ready low for the first 4 cycles of a 5-beat stream
    bp_num[0] = 32'h0000_1000; bp_exp[0] = 16'h0001;
    bp_num[1] = 32'h0000_2000; bp_exp[1] = 16'h0002;
    bp_num[2] = 32'h0000_3000; bp_exp[2] = 16'h0003;
    bp_num[3] = 32'h0000_4000; bp_exp[3] = 16'h0004;
    bp_num[4] = 32'h0080_0000; bp_exp[4] = 16'h0800;
    sent = 0;
    got  = 0;
    held = '0;
    mode = 2'd0;
    for (int cyc = 0; cyc < 40 && got < 5; cyc++) begin
      out_ready = (cyc >= 4);
      in_valid  = (sent < 5);
      if (sent < 5) num = bp_num[sent];
      #1;
      if (cyc == 2 || cyc == 3) chk("bp_in_ready_low", 32'(in_ready), 32'd0);
      if (cyc == 2) held = out;
      if (cyc == 3) begin
        chk("bp_hold_valid", 32'(out_valid), 32'd1);
        chk("bp_hold_out", 32'(out), 32'(held));
      end
      take_in = in_valid && in_ready;
      if (out_valid && out_ready) begin
        chk("bp_order", 32'(out), 32'(bp_exp[got]));
        got++;
      end
      @(posedge clk); #1;
      if (take_in) sent++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    chk("bp_sent", 32'(sent), 32'd5);
    chk("bp_got", 32'(got), 32'd5);
    chk("bp_no_dup", 32'(out_valid), 32'd0);
    chk("bp_cnt", 32'(sat_count), 32'd3);

    beat("clr_vs_inc", 32'h0800_0000, 2'd0, 3'd0, 16'h0, 16'h7FFF, 1'b1, 1'b1);
    chk("cnt_cleared", 32'(sat_count), 32'd0);

    beat("round", 32'h0000_0800, 2'd0, 3'd0, 16'h0, RoundExp, 1'b0, 1'b0);
    beat("pre_rst_sat", 32'h0800_0000, 2'd0, 3'd0, 16'h0, 16'h7FFF, 1'b1, 1'b0);
    chk("cnt_pre_rst", 32'(sat_count), 32'd1);

    // Reset with a beat sitting in stage 1
    num      = 32'h0100_0000;
    mode     = 2'd0;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    rst_n    = 1'b0;
    @(posedge clk); #1;
    chk("midrst_valid", 32'(out_valid), 32'd0);
    chk("midrst_out", 32'(out), 32'd0);
    chk("midrst_sat", 32'(out_sat), 32'd0);
    chk("midrst_cnt", 32'(sat_count), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("midrst_drop", 32'(out_valid), 32'd0);
    chk("midrst_in_ready", 32'(in_ready), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
